mux_nway_rr: RTL and testbench

Parametrised N-way, W-bit arbitrated multiplexer with a registered output stage and valid/ready handshakes on every channel. It generalises the fixed 8-way/16-bit selector: the select is no longer an input, and the block arbitrates among requesting channels itself, either round-robin or fixed-priority. It sits wherever several producers share one datapath, such as register-file write-back or I/O funnels into the Hack memory bus. Sustained throughput is one word per clock.

---
 rtl/mux_nway_rr.sv | 67 ++++++
 tb/tb_mux_nway_rr.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mux_nway_rr.sv
// mux_nway_rr: N-way arbitrated multiplexer (round-robin or fixed priority)
// with a registered output stage and valid/ready handshakes on every channel.
module mux_nway_rr #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 8,
    parameter int RR       = 1,
    localparam int SEL_W   = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_sel
);
    localparam logic [SEL_W:0] CH_W = (SEL_W+1)'(CHANNELS);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] gnt_idx;
    logic [SEL_W-1:0] cand [CHANNELS];
    logic [WIDTH-1:0] chan [CHANNELS];
    logic             gnt_any;
    logic             load;

    // cand[i] is the channel visited i-th in the search starting at ptr,
    // with an explicit modulo wrap so non-power-of-two counts work.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SEL_W:0] s;
        assign s       = {1'b0, ptr} + (SEL_W+1)'(i);
        assign cand[i] = SEL_W'((s >= CH_W) ? s - CH_W : s);
        assign chan[i] = in_data[i*WIDTH +: WIDTH];
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (in_valid[cand[i]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[i];
            end
        end
    end

    assign load     = !out_valid || out_ready;
    assign in_ready = (reset_n && load && gnt_any) ? CHANNELS'(1) << gnt_idx : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            out_valid <= gnt_any;
            if (gnt_any) begin
                out_data <= chan[gnt_idx];
                out_sel  <= gnt_idx;
                if (RR != 0)
                    ptr <= (gnt_idx == SEL_W'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mux_nway_rr.sv
// tb_mux_nway_rr: directed checks of round-robin 8x16, fixed-priority 8x16
// and round-robin 5x8 instances of mux_nway_rr.
module tb_mux_nway_rr;
    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    int           checks = 0;
    int           errors = 0;

    logic [127:0] d8 = '0, df = '0;
    logic [7:0]   v8 = '0, vf = '0, r8, rf;
    logic [15:0]  od8, odf;
    logic         ov8, ovf, ordy8 = 1'b1, ordyf = 1'b1;
    logic [2:0]   os8, osf;

    logic [39:0]  d5 = '0;
    logic [4:0]   v5 = '0, r5;
    logic [7:0]   od5;
    logic         ov5, ordy5 = 1'b1;
    logic [2:0]   os5;

    always #5 clk = ~clk;

    mux_nway_rr #(.WIDTH(16), .CHANNELS(8), .RR(1)) u_rr8 (
        .clk(clk), .reset_n(reset_n), .in_data(d8), .in_valid(v8), .in_ready(r8),
        .out_data(od8), .out_valid(ov8), .out_ready(ordy8), .out_sel(os8));

    mux_nway_rr #(.WIDTH(16), .CHANNELS(8), .RR(0)) u_fp8 (
        .clk(clk), .reset_n(reset_n), .in_data(df), .in_valid(vf), .in_ready(rf),
        .out_data(odf), .out_valid(ovf), .out_ready(ordyf), .out_sel(osf));

    mux_nway_rr #(.WIDTH(8), .CHANNELS(5), .RR(1)) u_rr5 (
        .clk(clk), .reset_n(reset_n), .in_data(d5), .in_valid(v5), .in_ready(r5),
        .out_data(od5), .out_valid(ov5), .out_ready(ordy5), .out_sel(os5));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            d8[k*16 +: 16] = 16'h0100 + 16'(k);
            df[k*16 +: 16] = 16'h0100 + 16'(k);
        end
        for (int k = 0; k < 5; k++) d5[k*8 +: 8] = 8'hA0 + 8'(k);
        d8[1*16 +: 16] = 16'h1234;
        v8 = 8'h02;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(r8), 32'h0);
        chk("rst_valid", 32'(ov8), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("ch1_ready", 32'(r8), 32'h02);
        @(negedge clk);
        chk("ch1_valid", 32'(ov8), 32'h1);
        chk("ch1_data", 32'(od8), 32'h1234);
        chk("ch1_sel", 32'(os8), 32'h1);
        v8 = 8'h00;
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(ov8), 32'h0);
        chk("midrst_data", 32'(od8), 32'h0);
        chk("midrst_sel", 32'(os8), 32'h0);
        #1 reset_n = 1'b1;
        d8[1*16 +: 16] = 16'h0101;
        v8 = 8'h03;
        #1 chk("postrst_ready", 32'(r8), 32'h01);
        @(negedge clk);
        chk("postrst_sel", 32'(os8), 32'h0);
        chk("postrst_data", 32'(od8), 32'h0100);

        d8[3*16 +: 16] = 16'hBEEF;
        v8 = 8'h08;
        #1 chk("single_ready", 32'(r8), 32'h08);
        @(negedge clk);
        chk("single_valid", 32'(ov8), 32'h1);
        chk("single_data", 32'(od8), 32'hBEEF);
        chk("single_sel", 32'(os8), 32'h3);
        v8 = 8'h00;
        @(negedge clk);
        chk("idle_valid", 32'(ov8), 32'h0);
        chk("idle_data_hold", 32'(od8), 32'hBEEF);
        chk("idle_sel_hold", 32'(os8), 32'h3);

        d8[3*16 +: 16] = 16'h0103;
        v8 = 8'h80;
        @(negedge clk);
        chk("ch7_sel", 32'(os8), 32'h7);
        v8 = 8'hFF;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rr_valid", 32'(ov8), 32'h1);
            chk("rr_sel", 32'(os8), 32'(k % 8));
            chk("rr_data", 32'(od8), 32'h0100 + 32'(k % 8));
        end

        ordy8 = 1'b0;
        v8 = 8'h44;
        #1 chk("bp_ready0", 32'(r8), 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_ready", 32'(r8), 32'h0);
            chk("bp_valid", 32'(ov8), 32'h1);
            chk("bp_data", 32'(od8), 32'h0101);
            chk("bp_sel", 32'(os8), 32'h1);
        end
        ordy8 = 1'b1;
        #1 chk("bp_release_ready", 32'(r8), 32'h04);
        @(negedge clk);
        chk("bp_next_valid", 32'(ov8), 32'h1);
        chk("bp_next_sel", 32'(os8), 32'h2);
        chk("bp_next_data", 32'(od8), 32'h0102);
        #1 chk("bp_after_ready", 32'(r8), 32'h40);
        @(negedge clk);
        chk("bp_after_sel", 32'(os8), 32'h6);
        v8 = 8'h00;

        vf = 8'h24;
        #1 chk("fp_ready", 32'(rf), 32'h04);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("fp_sel", 32'(osf), 32'h2);
            chk("fp_data", 32'(odf), 32'h0102);
        end
        vf = 8'h20;
        @(negedge clk);
        chk("fp_drop_sel", 32'(osf), 32'h5);
        chk("fp_drop_data", 32'(odf), 32'h0105);
        vf = 8'h00;

        v5 = 5'b00100;
        @(negedge clk);
        chk("w5_pre_sel", 32'(os5), 32'h2);
        v5 = 5'b11001;
        #1 chk("w5_ready", 32'(r5), 32'h08);
        @(negedge clk);
        chk("w5_sel_a", 32'(os5), 32'h3);
        chk("w5_data_a", 32'(od5), 32'hA3);
        @(negedge clk);
        chk("w5_sel_b", 32'(os5), 32'h4);
        chk("w5_data_b", 32'(od5), 32'hA4);
        #1 chk("w5_wrap_ready", 32'(r5), 32'h01);
        @(negedge clk);
        chk("w5_sel_c", 32'(os5), 32'h0);
        chk("w5_data_c", 32'(od5), 32'hA0);
        @(negedge clk);
        chk("w5_sel_d", 32'(os5), 32'h3);
        #1 chk("w5_last_ready", 32'(r5), 32'h10);
        v5 = 5'b00000;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
